spi_frame_master: RTL and testbench

SPI_FRAME_MASTER -- requirements
Module: spi_frame_master

---
 rtl/spi_frame_pkg.sv | 8 +
 rtl/spi_cmd_fifo.sv | 31 +++
 rtl/spi_frame_master.sv | 118 +++++++++++
 tb/tb_spi_frame_master.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: FSM state encoding and default parameters for spi_frame_master.
package spi_frame_pkg;
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, LAG, GAP} state_t;
  localparam int DEF_DATA_W = 24;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_GAP_H = 3;
  localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo: synchronous DEPTH x DATA_W command FIFO with show-ahead read port.
module spi_cmd_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk) if (push && !full) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/spi_frame_master.sv
// spi_frame_master: FIFO-fed SPI frame transmitter; define SPI_MISO_EN to add MISO capture.
module spi_frame_master
  import spi_frame_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int GAP_H = DEF_GAP_H,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              busy,
  output logic              spi_data_out,
  output logic              spi_clk_out,
  output logic              spi_en_out
`ifdef SPI_MISO_EN
  ,
  input  logic              spi_data_in,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
`endif
);
  localparam int H = CLK_DIV / 2;
  localparam logic [15:0] H_END = 16'(H - 1);
  localparam logic [15:0] SH_END = 16'(2 * DATA_W - 1);
  localparam logic [15:0] GAP_END = 16'(GAP_H - 1);
  if (CLK_DIV < 2 || CLK_DIV % 2 != 0) begin : g_bad_div
    $error("CLK_DIV must be even and >= 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= 2");
  end
  if (DATA_W < 8 || DATA_W > 32) begin : g_bad_width
    $error("DATA_W must be in 8..32");
  end
  if (GAP_H < 1) begin : g_bad_gap
    $error("GAP_H must be >= 1");
  end
  state_t state, state_n;
  logic [15:0] cnt, hp;
  logic [DATA_W-1:0] sh, fifo_q;
  logic ready_q, full, empty, pop, push, end_h, active, sclk_d;
  assign push = wr_valid && wr_ready;
  assign wr_ready = ready_q && !full;
  assign busy = !empty || state != IDLE;
  assign end_h = cnt == H_END;
  assign active = state inside {LEAD, SHIFT, LAG};
  assign sclk_d = state == SHIFT && hp[0];
  spi_cmd_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(wr_data),
    .dout(fifo_q), .full(full), .empty(empty)
  );
  always_comb begin
    state_n = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        state_n = empty ? IDLE : LEAD;
        pop = !empty;
      end
      LEAD: state_n = end_h ? SHIFT : LEAD;
      SHIFT: state_n = (end_h && hp == SH_END) ? LAG : SHIFT;
      LAG: state_n = end_h ? GAP : LAG;
      GAP: if (end_h && hp == GAP_END) begin
        state_n = empty ? IDLE : LEAD;
        pop = !empty;
      end
      default: state_n = IDLE;
    endcase
  end
  // SPI pins are registered from the current state, so they trail the FSM by one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      hp <= '0;
      sh <= '0;
      ready_q <= 1'b0;
      spi_en_out <= 1'b1;
      spi_clk_out <= 1'b0;
      spi_data_out <= 1'b0;
    end else begin
      state <= state_n;
      ready_q <= 1'b1;
      if (state_n != state || state == IDLE) begin
        cnt <= '0;
        hp <= '0;
      end else if (end_h) begin
        cnt <= '0;
        hp <= hp + 16'd1;
      end else begin
        cnt <= cnt + 16'd1;
      end
      if (pop) sh <= fifo_q;
      else if (state == SHIFT && end_h && hp[0] && hp != SH_END) sh <= sh << 1;
      spi_en_out <= !active;
      spi_clk_out <= sclk_d;
      spi_data_out <= active && sh[DATA_W-1];
    end
  end
`ifdef SPI_MISO_EN
  logic [DATA_W-1:0] rx;
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= state == LAG && end_h;
      if (sclk_d && !spi_clk_out) rx <= {rx[DATA_W-2:0], spi_data_in};
      if (state == LAG && end_h) rd_data <= rx;
    end
  end
`endif
endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master: directed plus randomized checks of spi_frame_master against a pin-level frame decoder.
`timescale 1ns/1ps
module tb_spi_frame_master;
  logic clk = 0, reset = 0;
  logic wr_valid = 0, wr_valid2 = 0;
  logic [23:0] wr_data = '0;
  logic [7:0] wr_data2 = '0;
  logic wr_ready, busy, sdo, sclk_o, en_o;
  logic wr_ready2, busy2, sdo2, sclk2, en2;
  int checks = 0, failures = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
`ifdef SPI_MISO_EN
  logic [23:0] rd_data;
  logic [7:0] rd_data2;
  logic rd_valid, rd_valid2;
  int rd_pulses = 0;
  always @(negedge clk) if (rd_valid) rd_pulses++;
`endif
  spi_frame_master u_dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .spi_data_out(sdo), .spi_clk_out(sclk_o),
    .spi_en_out(en_o)
`ifdef SPI_MISO_EN
    , .spi_data_in(sdo), .rd_data(rd_data), .rd_valid(rd_valid)
`endif
  );
  spi_frame_master #(.DATA_W(8), .CLK_DIV(2)) u_small (
    .clk(clk), .reset(reset), .wr_valid(wr_valid2), .wr_data(wr_data2),
    .wr_ready(wr_ready2), .busy(busy2), .spi_data_out(sdo2), .spi_clk_out(sclk2),
    .spi_en_out(en2)
`ifdef SPI_MISO_EN
    , .spi_data_in(sdo2), .rd_data(rd_data2), .rd_valid(rd_valid2)
`endif
  );
  // Pin-level decoder for both instances: frames, EN edge times, SCLK spacing, data stability
  logic [1:0] m_en, m_sclk, m_d;
  logic [1:0] p_en = 2'b11, p_sclk = 2'b00, p_d = 2'b00;
  assign m_en = {en2, en_o};
  assign m_sclk = {sclk2, sclk_o};
  assign m_d = {sdo2, sdo};
  int bits[2], rises[2], last_rise[2], per_bad[2], stab_bad[2], got_n[2];
  int nb[2][64], fall[2][64], rise[2][64];
  logic [31:0] fr[2];
  logic [31:0] got[2][64];
  int div[2] = '{4, 2};
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (m_sclk[m] && !p_sclk[m]) rises[m]++;
      if (reset && got_n[m] < 64) begin
        if (p_en[m] && !m_en[m]) begin
          bits[m] = 0;
          fr[m] = '0;
          fall[m][got_n[m]] = cyc;
        end
        if (!m_en[m] && m_sclk[m] && !p_sclk[m]) begin
          if (bits[m] > 0 && cyc - last_rise[m] != div[m]) per_bad[m]++;
          last_rise[m] = cyc;
          fr[m] = {fr[m][30:0], m_d[m]};
          bits[m]++;
        end
        if (m_sclk[m] && p_sclk[m] && m_d[m] != p_d[m]) stab_bad[m]++;
        if (!p_en[m] && m_en[m]) begin
          got[m][got_n[m]] = fr[m];
          nb[m][got_n[m]] = bits[m];
          rise[m][got_n[m]] = cyc;
          got_n[m]++;
        end
      end
      p_en[m] = m_en[m];
      p_sclk[m] = m_sclk[m];
      p_d[m] = m_d[m];
    end
  end
  logic [23:0] exp0[64];
  int exp_n0 = 0, acc_cyc = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic write0(input logic [23:0] w, output bit stalled);
    int t = 0;
    stalled = 0;
    step();
    wr_valid = 1;
    wr_data = w;
    while (!wr_ready && t < 3000) begin
      stalled = 1;
      step();
      t++;
    end
    chk("wr_accept", wr_ready, 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (exp_n0 < 64) exp0[exp_n0++] = w;
  endtask
  task automatic idle0();
    step();
    wr_valid = 0;
  endtask
  task automatic write1(input logic [7:0] w);
    int t = 0;
    step();
    wr_valid2 = 1;
    wr_data2 = w;
    while (!wr_ready2 && t < 100) begin
      step();
      t++;
    end
    chk("wr_small_accept", wr_ready2, 1);
    @(posedge clk);
    #1;
  endtask
  task automatic wait_frames(input int m, input int n, input string tag);
    int t = 0;
    while (got_n[m] < n && t < 5000) begin
      step();
      t++;
    end
    chk(tag, got_n[m], n);
  endtask
  task automatic cmp_frames(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      chk($sformatf("frame%0d_data", i), got[0][i], {8'd0, exp0[i]});
      chk($sformatf("frame%0d_bits", i), nb[0][i], 24);
    end
  endtask
  initial begin
    bit st, stall_any;
    int r0, t;
    repeat (3) step();
    chk("rst_en", en_o, 1);
    chk("rst_sclk", sclk_o, 0);
    chk("rst_data", sdo, 0);
    chk("rst_ready", wr_ready, 0);
    chk("rst_busy", busy, 0);
    reset = 1;
    chk("ready_before_edge", wr_ready, 0);
    step();
    chk("ready_after_edge", wr_ready, 1);
    write0(24'hA5F00F, st);
    idle0();
    wait_frames(0, 1, "single_count");
    cmp_frames(0, 1);
    chk("single_en_fall", fall[0][0], acc_cyc + 2);
    chk("single_en_low_len", rise[0][0] - fall[0][0], 100);
    t = 0;
    while (busy && t < 200) begin
      step();
      t++;
    end
    chk("single_idle_busy", busy, 0);
    chk("single_idle_en", en_o, 1);
`ifdef SPI_MISO_EN
    chk("miso_rd_data", rd_data, 24'hA5F00F);
    chk("miso_pulses", rd_pulses, 1);
`endif
    stall_any = 0;
    for (int k = 0; k < 4; k++) begin
      write0(24'($urandom), st);
      stall_any |= st;
    end
    idle0();
    wait_frames(0, 5, "b2b_count");
    chk("b2b_no_stall", stall_any, 0);
    cmp_frames(1, 5);
    for (int i = 2; i < 5; i++) begin
      chk($sformatf("b2b_gap%0d", i), fall[0][i] - rise[0][i-1], 6);
      chk($sformatf("b2b_period%0d", i), fall[0][i] - fall[0][i-1], 106);
    end
    stall_any = 0;
    for (int k = 0; k < 6; k++) begin
      write0(24'($urandom), st);
      stall_any |= st;
    end
    idle0();
    wait_frames(0, 11, "fill_count");
    chk("fill_stall_seen", stall_any, 1);
    cmp_frames(5, 11);
    write0(24'h123456, st);
    write0(24'h654321, st);
    idle0();
    t = 0;
    while (bits[0] != 9 && t < 2000) begin
      step();
      t++;
    end
    chk("abort_reach_bit9", bits[0], 9);
    repeat (3) step();
    reset = 0;
    step();
    chk("abort_en", en_o, 1);
    chk("abort_sclk", sclk_o, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", wr_ready, 0);
    r0 = rises[0];
    reset = 1;
    repeat (400) step();
    chk("abort_no_sclk", rises[0], r0);
    chk("abort_no_frame", got_n[0], 11);
    chk("abort_idle", busy, 0);
    exp_n0 = 11;
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 120)) step();
      write0(24'($urandom), st);
      idle0();
    end
    wait_frames(0, 19, "rand_count");
    cmp_frames(11, 19);
    chk("sclk_spacing", per_bad[0], 0);
    chk("data_stable_high", stab_bad[0], 0);
`ifdef SPI_MISO_EN
    chk("miso_pulse_total", rd_pulses, got_n[0]);
`endif
    write1(8'h81);
    write1(8'h3C);
    step();
    wr_valid2 = 0;
    wait_frames(1, 2, "small_count");
    chk("small_data0", got[1][0], 32'h81);
    chk("small_data1", got[1][1], 32'h3C);
    chk("small_bits", nb[1][0], 8);
    chk("small_period", fall[1][1] - fall[1][0], 21);
    chk("small_en_low_len", rise[1][0] - fall[1][0], 18);
    chk("small_sclk_spacing", per_bad[1], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
